lc3_writeback_unit: RTL and testbench

- Write-back stage directly upstream of the LC-3 register file. It drives the file's destination select, load enable and write data.
- Arbitrates write-back requests from the ALU path and the memory-load path using valid/ready handshakes. Registers the winner into a single output stage and updates the N/Z/P condition codes.
- Keeps a per-register outstanding-write scoreboard so the decode/issue logic can detect RAW hazards against R0–R7.

---
 rtl/lc3_writeback_unit.sv | 121 ++++++++++++
 tb/tb_lc3_writeback_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_writeback_unit.sv
// LC-3 write-back stage: arbitrates ALU and memory-load results into the register file,
// maintains N/Z/P condition codes and a per-register outstanding-write scoreboard.
module lc3_writeback_unit #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [2:0]        alu_dr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_setcc,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [2:0]        mem_dr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_setcc,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [2:0]        issue_dr,
  output logic [7:0]        busy,
  output logic [2:0]        rf_dr,
  output logic              rf_ld_reg,
  output logic [DATA_W-1:0] rf_data,
  output logic [2:0]        nzp
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_ldReg;
  logic [2:0]        r_dr;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_nzp;
  logic [CNT_W-1:0]  r_cnt [8];
  logic [CNT_W-1:0]  w_cntNext [8];

  logic              w_memAcc;
  logic              w_aluAcc;
  logic              w_wbAcc;
  logic [2:0]        w_wbDr;
  logic [DATA_W-1:0] w_wbData;
  logic              w_wbSetcc;
  logic              w_issueAcc;
  logic              w_n;
  logic              w_z;

  // Memory loads always win; the ALU only proceeds when no load is presented.
  assign mem_ready   = !flush;
  assign alu_ready   = !flush && !mem_valid;
  assign issue_ready = !flush && (r_cnt[issue_dr] != CNT_MAX);

  assign w_memAcc   = mem_valid && mem_ready;
  assign w_aluAcc   = alu_valid && alu_ready;
  assign w_wbAcc    = w_memAcc || w_aluAcc;
  assign w_issueAcc = issue_valid && issue_ready;

  always_comb begin
    w_wbDr    = alu_dr;
    w_wbData  = alu_data;
    w_wbSetcc = alu_setcc;
    if (w_memAcc) begin
      w_wbDr    = mem_dr;
      w_wbData  = mem_data;
      w_wbSetcc = mem_setcc;
    end
  end

  assign w_n = w_wbData[DATA_W-1];
  assign w_z = (w_wbData == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ldReg <= 1'b0;
      r_dr    <= '0;
      r_data  <= '0;
      r_nzp   <= 3'b010;
    end else begin
      r_ldReg <= w_wbAcc;
      if (w_wbAcc) begin
        r_dr   <= w_wbDr;
        r_data <= w_wbData;
        if (w_wbSetcc) r_nzp <= {w_n, w_z, !w_n && !w_z};
      end
    end
  end

  // A write-back to an idle register is still performed but must not wrap its counter.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_cntNext[i] = r_cnt[i];
      if (w_issueAcc && (issue_dr == 3'(i)) && !(w_wbAcc && (w_wbDr == 3'(i))))
        w_cntNext[i] = r_cnt[i] + 1'b1;
      else if (w_wbAcc && (w_wbDr == 3'(i)) && !(w_issueAcc && (issue_dr == 3'(i)))
               && (r_cnt[i] != '0))
        w_cntNext[i] = r_cnt[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) r_cnt[i] <= w_cntNext[i];
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < 8; i++) busy[i] = (r_cnt[i] != '0);
  end

  assign rf_ld_reg = r_ldReg;
  assign rf_dr     = r_dr;
  assign rf_data   = r_data;
  assign nzp       = r_nzp;

endmodule

// File: tb/tb_lc3_writeback_unit.sv
// Self-checking bench for lc3_writeback_unit: vector table plus hand-written
// multi-cycle sequences, with a queue scoreboard for register-file writes.
module tb_lc3_writeback_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        alu_valid, alu_ready, alu_setcc;
  logic [2:0]  alu_dr;
  logic [15:0] alu_data;
  logic        mem_valid, mem_ready, mem_setcc;
  logic [2:0]  mem_dr;
  logic [15:0] mem_data;
  logic        issue_valid, issue_ready;
  logic [2:0]  issue_dr;
  logic [7:0]  busy;
  logic [2:0]  rf_dr;
  logic        rf_ld_reg;
  logic [15:0] rf_data;
  logic [2:0]  nzp;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic [2:0]  dr;
    logic [15:0] data;
  } wb_t;
  wb_t sbQ[$];

  typedef struct {
    logic        aluV;
    logic [2:0]  aluDr;
    logic [15:0] aluD;
    logic        aluCc;
    logic        memV;
    logic [2:0]  memDr;
    logic [15:0] memD;
    logic        memCc;
    logic [2:0]  expNzp;
  } vec_t;
  vec_t vecs[8];

  lc3_writeback_unit #(.DATA_W(16), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dr(alu_dr),
    .alu_data(alu_data), .alu_setcc(alu_setcc),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dr(mem_dr),
    .mem_data(mem_data), .mem_setcc(mem_setcc),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_dr(issue_dr),
    .busy(busy), .rf_dr(rf_dr), .rf_ld_reg(rf_ld_reg), .rf_data(rf_data), .nzp(nzp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Every register-file write must match the oldest expected write in the queue.
  always @(posedge clk) begin
    #1;
    if (reset_n && rf_ld_reg) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_write", 32'(rf_ld_reg), 32'd0);
      end else begin
        wb_t e;
        e = sbQ.pop_front();
        checkOutput("sb_rf_dr", 32'(rf_dr), 32'(e.dr));
        checkOutput("sb_rf_data", 32'(rf_data), 32'(e.data));
      end
    end
  end

  task automatic pushWb(input logic [2:0] dr, input logic [15:0] data);
    wb_t e;
    e.dr = dr;
    e.data = data;
    sbQ.push_back(e);
  endtask

  task automatic driveAlu(input logic v, input logic [2:0] dr, input logic [15:0] d,
                          input logic cc);
    alu_valid = v; alu_dr = dr; alu_data = d; alu_setcc = cc;
  endtask

  task automatic driveMem(input logic v, input logic [2:0] dr, input logic [15:0] d,
                          input logic cc);
    mem_valid = v; mem_dr = dr; mem_data = d; mem_setcc = cc;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    driveAlu(v.aluV, v.aluDr, v.aluD, v.aluCc);
    driveMem(v.memV, v.memDr, v.memD, v.memCc);
    #1;
    checkOutput("vec_alu_ready", 32'(alu_ready), 32'(!v.memV));
    checkOutput("vec_mem_ready", 32'(mem_ready), 32'd1);
    if (v.memV) pushWb(v.memDr, v.memD);
    else if (v.aluV) pushWb(v.aluDr, v.aluD);
    @(posedge clk); #1;
    checkOutput("vec_ld_reg", 32'(rf_ld_reg), 32'(v.aluV || v.memV));
    checkOutput("vec_nzp", 32'(nzp), 32'(v.expNzp));
    checkOutput("vec_busy", 32'(busy), 32'h00);
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd1, 16'h0005, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'b001};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd2, 16'h0000, 1'b1, 3'b010};
    vecs[2] = '{1'b1, 3'd7, 16'h7FFF, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'b010};
    vecs[3] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd6, 16'hFFFF, 1'b1, 3'b100};
    vecs[4] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'b100};
    vecs[5] = '{1'b1, 3'd4, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'b010};
    vecs[6] = '{1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'b010};
    vecs[7] = '{1'b1, 3'd3, 16'h1234, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'b001};

    reset_n = 1'b0; flush = 1'b0;
    issue_valid = 1'b0; issue_dr = 3'd0;
    driveAlu(1'b0, 3'd0, 16'h0, 1'b0);
    driveMem(1'b0, 3'd0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("rst_busy", 32'(busy), 32'h00);
      checkOutput("rst_nzp", 32'(nzp), 32'b010);
      checkOutput("rst_ld_reg", 32'(rf_ld_reg), 32'd0);
    end
    checkOutput("rst_rf_dr", 32'(rf_dr), 32'd0);
    checkOutput("rst_rf_data", 32'(rf_data), 32'h0);

    // Reserve R3, then the ALU retires it with a negative result.
    @(negedge clk);
    issue_valid = 1'b1; issue_dr = 3'd3;
    #1 checkOutput("r3_issue_ready", 32'(issue_ready), 32'd1);
    @(posedge clk); #1;
    checkOutput("r3_busy_set", 32'(busy), 32'h08);
    @(negedge clk);
    issue_valid = 1'b0;
    driveAlu(1'b1, 3'd3, 16'h8001, 1'b1);
    #1 checkOutput("r3_alu_ready", 32'(alu_ready), 32'd1);
    pushWb(3'd3, 16'h8001);
    @(posedge clk); #1;
    checkOutput("r3_ld_reg", 32'(rf_ld_reg), 32'd1);
    checkOutput("r3_nzp", 32'(nzp), 32'b100);
    checkOutput("r3_busy_clr", 32'(busy), 32'h00);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
    @(negedge clk);
    driveAlu(1'b0, 3'd0, 16'h0, 1'b0);
    driveMem(1'b0, 3'd0, 16'h0, 1'b0);

    // Both sources valid: memory first, ALU on the following edge.
    @(negedge clk);
    driveAlu(1'b1, 3'd1, 16'h0005, 1'b0);
    driveMem(1'b1, 3'd2, 16'h0000, 1'b1);
    #1;
    checkOutput("arb_alu_ready", 32'(alu_ready), 32'd0);
    checkOutput("arb_mem_ready", 32'(mem_ready), 32'd1);
    pushWb(3'd2, 16'h0000);
    @(posedge clk); #1;
    checkOutput("arb_ld1", 32'(rf_ld_reg), 32'd1);
    checkOutput("arb_nzp_mem", 32'(nzp), 32'b010);
    @(negedge clk);
    driveMem(1'b0, 3'd0, 16'h0, 1'b0);
    #1 checkOutput("arb_alu_ready2", 32'(alu_ready), 32'd1);
    pushWb(3'd1, 16'h0005);
    @(posedge clk); #1;
    checkOutput("arb_ld2", 32'(rf_ld_reg), 32'd1);
    checkOutput("arb_nzp_hold", 32'(nzp), 32'b010);
    @(negedge clk);
    driveAlu(1'b0, 3'd0, 16'h0, 1'b0);
    @(posedge clk); #1;
    checkOutput("arb_ld_off", 32'(rf_ld_reg), 32'd0);

    // Saturate R5's counter and exercise same-edge issue/write-back.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      issue_valid = 1'b1; issue_dr = 3'd5;
      #1 checkOutput("r5_issue_ready", 32'(issue_ready), 32'd1);
    end
    @(posedge clk); #1;
    checkOutput("r5_busy", 32'(busy), 32'h20);
    @(negedge clk); #1;
    checkOutput("r5_full", 32'(issue_ready), 32'd0);
    issue_valid = 1'b0;
    driveAlu(1'b1, 3'd5, 16'h0042, 1'b0);
    pushWb(3'd5, 16'h0042);
    @(posedge clk);
    @(negedge clk);
    issue_valid = 1'b1; issue_dr = 3'd5;
    driveAlu(1'b1, 3'd5, 16'h0043, 1'b0);
    #1 checkOutput("r5_ready_after_wb", 32'(issue_ready), 32'd1);
    pushWb(3'd5, 16'h0043);
    @(posedge clk); #1;
    checkOutput("r5_busy_same_edge", 32'(busy), 32'h20);
    @(negedge clk);
    driveAlu(1'b0, 3'd0, 16'h0, 1'b0);
    #1 checkOutput("r5_ready_cnt2", 32'(issue_ready), 32'd1);
    @(negedge clk); #1;
    checkOutput("r5_full_again", 32'(issue_ready), 32'd0);
    issue_dr = 3'd6;
    driveAlu(1'b1, 3'd5, 16'h0044, 1'b0);
    #1 checkOutput("r6_issue_ready", 32'(issue_ready), 32'd1);
    pushWb(3'd5, 16'h0044);
    @(posedge clk); #1;
    checkOutput("r5r6_busy", 32'(busy), 32'h60);
    @(negedge clk);
    issue_valid = 1'b0;
    driveAlu(1'b1, 3'd5, 16'h0045, 1'b0);
    pushWb(3'd5, 16'h0045);
    @(posedge clk); #1;
    checkOutput("r5_drain1", 32'(busy), 32'h60);
    @(negedge clk);
    driveAlu(1'b1, 3'd5, 16'h0046, 1'b0);
    pushWb(3'd5, 16'h0046);
    @(posedge clk); #1;
    checkOutput("r5_drain2", 32'(busy), 32'h40);
    @(negedge clk);
    driveAlu(1'b0, 3'd0, 16'h0, 1'b0);

    // Flush with a pending ALU request and reservations outstanding.
    @(negedge clk);
    issue_valid = 1'b1; issue_dr = 3'd0;
    @(negedge clk);
    issue_dr = 3'd4;
    @(posedge clk); #1;
    checkOutput("fl_busy_pre", 32'(busy), 32'h51);
    @(negedge clk);
    issue_valid = 1'b0;
    flush = 1'b1;
    driveAlu(1'b1, 3'd0, 16'h0BAD, 1'b1);
    #1;
    checkOutput("fl_alu_ready", 32'(alu_ready), 32'd0);
    checkOutput("fl_mem_ready", 32'(mem_ready), 32'd0);
    checkOutput("fl_issue_ready", 32'(issue_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("fl_busy", 32'(busy), 32'h00);
    checkOutput("fl_ld_reg", 32'(rf_ld_reg), 32'd0);
    checkOutput("fl_nzp", 32'(nzp), 32'b010);
    @(negedge clk);
    flush = 1'b0;
    #1 checkOutput("fl_alu_ready_after", 32'(alu_ready), 32'd1);
    pushWb(3'd0, 16'h0BAD);
    @(posedge clk); #1;
    checkOutput("fl_ld_after", 32'(rf_ld_reg), 32'd1);
    checkOutput("fl_nzp_after", 32'(nzp), 32'b001);
    @(negedge clk);
    driveAlu(1'b0, 3'd0, 16'h0, 1'b0);

    // Asynchronous reset while a write pulse is on the register-file port.
    @(negedge clk);
    issue_valid = 1'b1; issue_dr = 3'd2;
    driveMem(1'b1, 3'd7, 16'h8000, 1'b1);
    pushWb(3'd7, 16'h8000);
    @(posedge clk); #1;
    checkOutput("ar_ld_pre", 32'(rf_ld_reg), 32'd1);
    checkOutput("ar_nzp_pre", 32'(nzp), 32'b100);
    checkOutput("ar_busy_pre", 32'(busy), 32'h04);
    issue_valid = 1'b0;
    driveMem(1'b0, 3'd0, 16'h0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("ar_ld", 32'(rf_ld_reg), 32'd0);
    checkOutput("ar_nzp", 32'(nzp), 32'b010);
    checkOutput("ar_busy", 32'(busy), 32'h00);
    checkOutput("ar_rf_dr", 32'(rf_dr), 32'd0);
    checkOutput("ar_rf_data", 32'(rf_data), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ar_ld_post", 32'(rf_ld_reg), 32'd0);
    checkOutput("ar_nzp_post", 32'(nzp), 32'b010);

    repeat (2) @(posedge clk);
    #2;
    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
